// File: rtl/activity_stretch.sv
// activity_stretch: 32-channel MIDI activity stretcher, fixed on-time then forced off-gap per channel.
module activity_stretch #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 1000,
  parameter int ON_TICKS  = 30,
  parameter int OFF_TICKS = 20,
  parameter int CNT_W     = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] rx_strobe,
  input  logic [15:0] tx_strobe,
  output logic [15:0] in_act,
  output logic [15:0] out_act,
  output logic        tick
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW = $clog2(DIV);
  localparam logic [CNT_W-1:0] ON_LD = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LD = CNT_W'(OFF_TICKS - 1);
  typedef enum logic [1:0] {IDLE, ON, OFF} st_t;
  logic [PW-1:0] pre;
  st_t st [32];
  logic [CNT_W-1:0] cnt [32];
  logic [31:0] pend, s, act;
  assign s = {tx_strobe, rx_strobe};
  assign tick = pre == PW'(DIV - 1);
  assign in_act = act[15:0];
  assign out_act = act[31:16];
  always_comb begin
    act = '0;
    for (int i = 0; i < 32; i++) act[i] = st[i] == ON;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      pend <= '0;
      for (int i = 0; i < 32; i++) begin
        st[i] <= IDLE;
        cnt[i] <= '0;
      end
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      for (int i = 0; i < 32; i++) begin
        case (st[i])
          IDLE: if (s[i]) begin
            st[i] <= ON;
            cnt[i] <= ON_LD;
            pend[i] <= 1'b0;
          end
          ON: begin
            // retrigger only arms one more blink; the on-time is never extended
            if (s[i]) pend[i] <= 1'b1;
            if (tick) begin
              cnt[i] <= cnt[i] == '0 ? OFF_LD : cnt[i] - 1'b1;
              if (cnt[i] == '0) st[i] <= OFF;
            end
          end
          OFF: if (tick && cnt[i] == '0) begin
            st[i] <= (pend[i] | s[i]) ? ON : IDLE;
            cnt[i] <= (pend[i] | s[i]) ? ON_LD : '0;
            pend[i] <= 1'b0;
          end else begin
            if (s[i]) pend[i] <= 1'b1;
            if (tick) cnt[i] <= cnt[i] - 1'b1;
          end
          default: st[i] <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_activity_stretch.sv
// tb_activity_stretch: directed stimulus with hand-computed expected waveforms, checked by a queue-driven monitor.
module tb_activity_stretch;
  logic clk, rst, tick;
  logic [15:0] rx_strobe, tx_strobe, in_act, out_act;
  int t = 0;
  int base = 0;
  int n_chk = 0;
  int n_err = 0;
  logic done = 1'b0;
  typedef struct {
    int cyc;
    string nm;
    logic [15:0] ia;
    logic [15:0] oa;
    logic tk;
  } exp_t;
  exp_t q[$];

  activity_stretch #(.CLK_HZ(1000), .TICK_HZ(100), .ON_TICKS(3), .OFF_TICKS(2), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .rx_strobe(rx_strobe), .tx_strobe(tx_strobe),
    .in_act(in_act), .out_act(out_act), .tick(tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) t <= t + 1;

  function automatic void push(string nm, int off, logic [15:0] ia, logic [15:0] oa, logic tk);
    exp_t e;
    e.cyc = base + off;
    e.nm = nm;
    e.ia = ia;
    e.oa = oa;
    e.tk = tk;
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && (q[0].cyc <= t || done)) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if (e.cyc != t) begin
        n_err++;
        $display("FAIL %s: check for cycle %0d not made, now cycle %0d", e.nm, e.cyc, t);
      end else if ({in_act, out_act, tick} !== {e.ia, e.oa, e.tk}) begin
        n_err++;
        $display("FAIL %s: got in_act=%h out_act=%h tick=%b, want in_act=%h out_act=%h tick=%b",
                 e.nm, in_act, out_act, tick, e.ia, e.oa, e.tk);
      end
    end
    if (done) begin
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic goto(input int n);
    while (t < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [15:0] r, input logic [15:0] w);
    rst = 1'b1;
    rx_strobe = r;
    tx_strobe = w;
    @(posedge clk);
    #1;
    base = t;
    push("rst_hold", 0, 16'h0, 16'h0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    rx_strobe = '0;
    tx_strobe = '0;
    base = t;
  endtask

  task automatic pulse(input int off, input logic [15:0] r, input logic [15:0] w);
    goto(base + off);
    rx_strobe = r;
    tx_strobe = w;
    @(posedge clk);
    #1;
    rx_strobe = '0;
    tx_strobe = '0;
  endtask

  initial begin
    rst = 1'b1;
    rx_strobe = '0;
    tx_strobe = '0;
    // reset with every strobe asserted, then prescaler phase
    do_reset(16'hFFFF, 16'hFFFF);
    push("rst_c0", 0, 16'h0, 16'h0, 1'b0);
    push("rst_c1", 1, 16'h0, 16'h0, 1'b0);
    push("tick_c8", 8, 16'h0, 16'h0, 1'b0);
    push("tick_c9", 9, 16'h0, 16'h0, 1'b1);
    push("tick_c10", 10, 16'h0, 16'h0, 1'b0);
    push("tick_c19", 19, 16'h0, 16'h0, 1'b1);
    push("tick_c29", 29, 16'h0, 16'h0, 1'b1);
    goto(base + 30);
    // single strobe on rx 5
    do_reset(16'h0, 16'h0);
    push("single_pre", 2, 16'h0, 16'h0, 1'b0);
    push("single_on", 3, 16'h0020, 16'h0, 1'b0);
    push("single_last", 29, 16'h0020, 16'h0, 1'b1);
    push("single_drop", 30, 16'h0, 16'h0, 1'b0);
    push("single_gap", 49, 16'h0, 16'h0, 1'b1);
    push("single_noblink", 50, 16'h0, 16'h0, 1'b0);
    push("single_60", 60, 16'h0, 16'h0, 1'b0);
    push("single_idle", 100, 16'h0, 16'h0, 1'b0);
    pulse(2, 16'h0020, 16'h0);
    goto(base + 101);
    // retrigger on tx 15
    do_reset(16'h0, 16'h0);
    push("retrig_on", 3, 16'h0, 16'h8000, 1'b0);
    push("retrig_last", 29, 16'h0, 16'h8000, 1'b1);
    push("retrig_dark0", 30, 16'h0, 16'h0, 1'b0);
    push("retrig_dark19", 49, 16'h0, 16'h0, 1'b1);
    push("retrig_blink", 50, 16'h0, 16'h8000, 1'b0);
    push("retrig_blink_last", 79, 16'h0, 16'h8000, 1'b1);
    push("retrig_off2", 80, 16'h0, 16'h0, 1'b0);
    push("retrig_off2_end", 99, 16'h0, 16'h0, 1'b1);
    push("retrig_idle", 100, 16'h0, 16'h0, 1'b0);
    push("retrig_idle2", 130, 16'h0, 16'h0, 1'b0);
    pulse(2, 16'h0, 16'h8000);
    pulse(15, 16'h0, 16'h8000);
    goto(base + 131);
    // saturated traffic on rx 0 for 200 cycles
    do_reset(16'h0, 16'h0);
    push("sat_on1", 3, 16'h0001, 16'h0, 1'b0);
    push("sat_on1_end", 29, 16'h0001, 16'h0, 1'b1);
    push("sat_off1", 30, 16'h0, 16'h0, 1'b0);
    push("sat_off1_end", 49, 16'h0, 16'h0, 1'b1);
    push("sat_on2", 50, 16'h0001, 16'h0, 1'b0);
    push("sat_on2_end", 79, 16'h0001, 16'h0, 1'b1);
    push("sat_off2", 80, 16'h0, 16'h0, 1'b0);
    push("sat_on3", 100, 16'h0001, 16'h0, 1'b0);
    push("sat_off3", 130, 16'h0, 16'h0, 1'b0);
    push("sat_on4", 150, 16'h0001, 16'h0, 1'b0);
    push("sat_off4_end", 199, 16'h0, 16'h0, 1'b1);
    push("sat_on5", 200, 16'h0001, 16'h0, 1'b0);
    push("sat_on5_end", 229, 16'h0001, 16'h0, 1'b1);
    push("sat_off5", 230, 16'h0, 16'h0, 1'b0);
    push("sat_pend_blink", 250, 16'h0001, 16'h0, 1'b0);
    push("sat_pend_end", 279, 16'h0001, 16'h0, 1'b1);
    push("sat_off6", 280, 16'h0, 16'h0, 1'b0);
    push("sat_idle", 300, 16'h0, 16'h0, 1'b0);
    goto(base + 2);
    rx_strobe = 16'h0001;
    goto(base + 202);
    rx_strobe = '0;
    goto(base + 301);
    // strobe on OFF-expiry tick (rx 1) and strobe on tick while IDLE (tx 3)
    do_reset(16'h0, 16'h0);
    push("sim_c9", 9, 16'h0002, 16'h0, 1'b1);
    push("sim_idle_tick_on", 10, 16'h0002, 16'h0008, 1'b0);
    push("sim_c29", 29, 16'h0002, 16'h0008, 1'b1);
    push("sim_c30", 30, 16'h0, 16'h0008, 1'b0);
    push("sim_idle_tick_last", 39, 16'h0, 16'h0008, 1'b1);
    push("sim_idle_tick_drop", 40, 16'h0, 16'h0, 1'b0);
    push("sim_c49", 49, 16'h0, 16'h0, 1'b1);
    push("sim_off_to_on", 50, 16'h0002, 16'h0, 1'b0);
    push("sim_c60", 60, 16'h0002, 16'h0, 1'b0);
    push("sim_c79", 79, 16'h0002, 16'h0, 1'b1);
    push("sim_c80", 80, 16'h0, 16'h0, 1'b0);
    push("sim_c100", 100, 16'h0, 16'h0, 1'b0);
    pulse(2, 16'h0002, 16'h0);
    pulse(9, 16'h0, 16'h0008);
    pulse(49, 16'h0002, 16'h0);
    goto(base + 101);
    // all 32 channels together
    do_reset(16'h0, 16'h0);
    push("all_pre", 2, 16'h0, 16'h0, 1'b0);
    push("all_on", 3, 16'hFFFF, 16'hFFFF, 1'b0);
    push("all_last", 29, 16'hFFFF, 16'hFFFF, 1'b1);
    push("all_drop", 30, 16'h0, 16'h0, 1'b0);
    push("all_noblink", 50, 16'h0, 16'h0, 1'b0);
    push("all_idle", 100, 16'h0, 16'h0, 1'b0);
    pulse(2, 16'hFFFF, 16'hFFFF);
    goto(base + 101);
    // reset while ON with a pending blink
    do_reset(16'h0, 16'h0);
    push("rmid_on", 3, 16'h0080, 16'h0, 1'b0);
    push("rmid_pre", 12, 16'h0080, 16'h0, 1'b0);
    pulse(2, 16'h0080, 16'h0);
    pulse(5, 16'h0080, 16'h0);
    goto(base + 12);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = t;
    push("rmid_clear", 0, 16'h0, 16'h0, 1'b0);
    push("rmid_tick8", 8, 16'h0, 16'h0, 1'b0);
    push("rmid_tick9", 9, 16'h0, 16'h0, 1'b1);
    push("rmid_tick19", 19, 16'h0, 16'h0, 1'b1);
    push("rmid_noblink", 37, 16'h0, 16'h0, 1'b0);
    push("rmid_c45", 45, 16'h0, 16'h0, 1'b0);
    push("rmid_c60", 60, 16'h0, 16'h0, 1'b0);
    goto(base + 61);
    done = 1'b1;
  end
endmodule
